// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the instruction-memory path.
// Holds: IMEM_DEPTH, INSTR_W, NOP_INSTR and the loader FSM state enum.
package mips_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int INSTR_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    FILL,
    DONE
  } ldr_state_t;

endpackage

// File: rtl/imem_checksum.sv
// XOR accumulator over accepted program words with clear and compare.
// Ports: clk, rst_n, clr, acc, din (word to fold), cmp (word to test), mismatch.
module imem_checksum
  import mips_pkg::*;
#(
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] cmp,
  output logic              mismatch
);

  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc) begin
      sum <= sum ^ din;
    end
  end

  assign mismatch = (sum != cmp);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams words into instruction RAM, NOP-fills, then runs CPU.
// Ports: CLK, RESET_N, start, in_valid/in_data/in_last/in_ready stream,
//   wr_en/wr_addr/wr_data RAM write, count, done, error, cpu_run.
// Build option: IMEM_CHECKSUM_EN adds a trailing XOR checksum word.
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int ADDR_W = 6,
  parameter int DATA_W = INSTR_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

  ldr_state_t state, state_d;

  logic [ADDR_W-1:0] faddr, faddr_d;
  logic [ADDR_W:0]   count_d, cnt_inc;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_en_d, done_d, error_d, run_d;
  logic              hs;

`ifdef IMEM_CHECKSUM_EN
  logic cks_clr, cks_acc, cks_mis;

  imem_checksum #(
    .DATA_W(DATA_W)
  ) u_cks (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .clr     (cks_clr),
    .acc     (cks_acc),
    .din     (in_data),
    .cmp     (in_data),
    .mismatch(cks_mis)
  );

  assign in_ready = ((state == LOAD) && (count < DEPTH_N))
                  || (state == CHECK);
`else
  assign in_ready = (state == LOAD) && (count < DEPTH_N);
`endif

  assign hs = in_valid && in_ready;
  assign cnt_inc = count + 1'b1;

  always_comb begin
    state_d   = state;
    count_d   = count;
    faddr_d   = faddr;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = done;
    error_d   = error;
    run_d     = cpu_run;
`ifdef IMEM_CHECKSUM_EN
    cks_clr   = 1'b0;
    cks_acc   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          error_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          cks_clr = 1'b1;
`endif
        end
      end
      LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count[ADDR_W-1:0];
          wr_data_d = in_data;
          count_d   = cnt_inc;
          faddr_d   = count[ADDR_W-1:0] + 1'b1;
`ifdef IMEM_CHECKSUM_EN
          cks_acc   = 1'b1;
`endif
          if (in_last) begin
`ifdef IMEM_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = (cnt_inc < DEPTH_N) ? FILL : DONE;
`endif
          end else if (cnt_inc == DEPTH_N) begin
            error_d = 1'b1;
            state_d = DONE;
          end
        end
      end
`ifdef IMEM_CHECKSUM_EN
      CHECK: begin
        // Checksum word is consumed, never written; its in_last is moot.
        if (hs) begin
          if (cks_mis) error_d = 1'b1;
          state_d = (count < DEPTH_N) ? FILL : DONE;
        end
      end
`endif
      FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = faddr;
        wr_data_d = NOP;
        faddr_d   = faddr + 1'b1;
        if (faddr == LAST_A) state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        run_d  = !error;
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          done_d  = 1'b0;
          run_d   = 1'b0;
          error_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          cks_clr = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      count   <= '0;
      faddr   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      cpu_run <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      faddr   <= faddr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      done    <= done_d;
      error   <= error_d;
      cpu_run <= run_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Expected RAM writes are queued as words are handed over and popped by a monitor.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, wr_en, done, error, cpu_run;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  count;

  imem_loader dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_last (in_last),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .count   (count),
    .done    (done),
    .error   (error),
    .cpu_run (cpu_run)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t sbq[$];
  wr_t em;
  int checks = 0;
  int failures = 0;
  int wptr = 0;
  int last_hs = 0;
  int last_wr = 0;
  int done_cyc = 0;
  logic [31:0] prog [64];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && wr_en) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none",
               wr_addr, wr_data);
      end else begin
        em = sbq.pop_front();
        chk("wr_addr", wr_addr, em.a);
        chk("wr_data", wr_data, em.d);
        chk("wr_cycle", cyc, em.c);
        last_wr = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last,
                           input bit cks);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (!in_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++;
      $error("FAIL hs_timeout observed=%0b expected=1", in_ready);
    end
    if (in_ready && !cks) begin
      sbq.push_back('{6'(wptr), d, cyc + 1});
      wptr++;
    end
    last_hs = cyc + 1;
    @(negedge CLK);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("count_hs", count, wptr);
  endtask

  task automatic finish_prog(input logic [31:0] x, input bit bad);
`ifdef IMEM_CHECKSUM_EN
    send_word(bad ? (x ^ 32'h7) : x, 1'b1, 1'b1);
`else
    if (bad) $display("note: checksum disabled, x=%0h", x);
`endif
    for (int a = wptr; a < 64; a++)
      sbq.push_back('{6'(a), 32'h0, last_hs + 1 + (a - wptr)});
  endtask

  task automatic load_prog(input int n, input bit bad);
    logic [31:0] x;
    x = '0;
    wptr = 0;
    for (int i = 0; i < n; i++) begin
      send_word(prog[i], i == n - 1, 1'b0);
      x ^= prog[i];
    end
    finish_prog(x, bad);
  endtask

  task automatic wait_done(input bit exp_err, input int exp_cnt);
    int t;
    t = 0;
    while (!done && t < 200) begin
      @(negedge CLK);
      t++;
    end
    done_cyc = cyc;
    chk("done", done, 1);
    chk("sb_empty", sbq.size(), 0);
    chk("error", error, exp_err);
    chk("cpu_run", cpu_run, !exp_err);
    chk("count_done", count, exp_cnt);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [31:0] x;
    idle(3);
    chk_reset_outs("rst");
    RESET_N = 1'b1;
    idle(2);
    chk("idle_ready", in_ready, 0);

    // 3-word program, ready held high
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;
    pulse_start();
    chk("load_ready", in_ready, 1);
    load_prog(3, 1'b0);
    wait_done(1'b0, 3);
    chk("done_lat3", done_cyc, last_wr + 1);

    // full 64-word program, restart from DONE
    for (int i = 0; i < 64; i++)
      prog[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_run", cpu_run, 0);
    load_prog(64, 1'b0);
    wait_done(1'b0, 64);
`ifndef IMEM_CHECKSUM_EN
    chk("done_lat64", done_cyc, last_wr + 1);
`endif

    // 65 words offered, no in_last
    pulse_start();
    wptr = 0;
    for (int i = 0; i < 64; i++)
      send_word(prog[i] ^ 32'hFF, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_ready", in_ready, 0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    wait_done(1'b1, 64);

    // backpressure: valid 1,0,0,1,0,0,1 with a stray start
    prog[0] = 32'h1111_0001;
    prog[1] = 32'h2222_0002;
    prog[2] = 32'h3333_0003;
    pulse_start();
    wptr = 0;
    send_word(prog[0], 1'b0, 1'b0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("start_ignored", count, 1);
    @(negedge CLK);
    send_word(prog[1], 1'b0, 1'b0);
    idle(2);
    send_word(prog[2], 1'b1, 1'b0);
    x = prog[0] ^ prog[1] ^ prog[2];
    finish_prog(x, 1'b0);
    wait_done(1'b0, 3);
    chk("done_lat_bp", done_cyc, last_wr + 1);

    // reset in the middle of the fill
    prog[0] = 32'h0000_00AA;
    prog[1] = 32'h0000_00BB;
    pulse_start();
    load_prog(2, 1'b0);
    idle(4);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_reset_outs("midfill");
    sbq.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(1);
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;
    pulse_start();
    load_prog(3, 1'b0);
    wait_done(1'b0, 3);
    chk("done_lat_rl", done_cyc, last_wr + 1);

`ifdef IMEM_CHECKSUM_EN
    prog[0] = 32'h1;
    prog[1] = 32'h2;
    pulse_start();
    load_prog(2, 1'b0);
    wait_done(1'b0, 2);
    pulse_start();
    load_prog(2, 1'b1);
    wait_done(1'b1, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
